// File: rtl/level_manager.sv
// level_manager: game FSM tracking level, lives, death/win pause and per-lane car speeds
module level_manager #(
    parameter int NUM_LANES   = 11,
    parameter int SPEED_W     = 4,
    parameter int MAX_LEVEL   = 8,
    parameter int START_LIVES = 3,
    parameter int FLASH_TICKS = 50
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tick,
    input  logic                         death_collision,
    input  logic                         win_collision,
    input  logic                         start,
    input  logic [NUM_LANES*SPEED_W-1:0] lane_base_speed,
    output logic [NUM_LANES*SPEED_W-1:0] lane_speed,
    output logic [3:0]                   current_level,
    output logic [1:0]                   lives,
    output logic [1:0]                   game_state,
    output logic                         round_reset,
    output logic                         flash
);
    localparam int CW = $clog2(FLASH_TICKS + 1);
    localparam int EW = SPEED_W + 4;

    typedef enum logic [1:0] {PLAY, DEATH, WIN, OVER} state_t;

    state_t                       state, state_n;
    logic [3:0]                   level_n, spd_level;
    logic [1:0]                   lives_n;
    logic [CW-1:0]                cnt, cnt_n;
    logic                         flash_n;
    logic [NUM_LANES*SPEED_W-1:0] speed_n;

    assign game_state  = state;
    assign round_reset = (state != PLAY);
    // speeds follow the registered level; during reset they are reloaded for level 1
    assign spd_level   = reset ? 4'd1 : current_level;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [EW-1:0] b, d;
        assign b = EW'(lane_base_speed[i*SPEED_W +: SPEED_W]);
        assign d = b - EW'(spd_level);
        assign speed_n[i*SPEED_W +: SPEED_W] = (b > EW'(spd_level)) ? d[SPEED_W-1:0] : SPEED_W'(1);
    end

    // next-state: collisions in PLAY, tick-paced pause in DEATH/WIN, restart in OVER
    always_comb begin
        state_n = state;
        level_n = current_level;
        lives_n = lives;
        cnt_n   = cnt;
        flash_n = flash;
        if (state == PLAY) begin
            flash_n = 1'b0;
            if (death_collision || win_collision) begin
                state_n = death_collision ? DEATH : WIN;
                cnt_n   = CW'(FLASH_TICKS);
            end
        end else if (state == OVER) begin
            flash_n = 1'b0;
            if (start) begin
                state_n = PLAY;
                level_n = 4'd1;
                lives_n = 2'(START_LIVES);
            end
        end else if (tick) begin
            flash_n = ~flash;
            cnt_n   = (cnt != '0) ? cnt - CW'(1) : '0;
            if (cnt <= CW'(1)) begin
                flash_n = 1'b0;
                cnt_n   = '0;
                if (state == DEATH) begin
                    state_n = (lives <= 2'd1) ? OVER : PLAY;
                    lives_n = (lives != 2'd0) ? lives - 2'd1 : 2'd0;
                end else begin
                    state_n = PLAY;
                    level_n = (current_level >= 4'(MAX_LEVEL)) ? 4'd1 : current_level + 4'd1;
                end
            end
        end
    end

    // game state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= PLAY;
            current_level <= 4'd1;
            lives         <= 2'(START_LIVES);
            cnt           <= '0;
            flash         <= 1'b0;
        end else begin
            state         <= state_n;
            current_level <= level_n;
            lives         <= lives_n;
            cnt           <= cnt_n;
            flash         <= flash_n;
        end
    end

    // registered effective lane speeds
    always_ff @(posedge clk) begin
        lane_speed <= speed_n;
    end
endmodule

// File: tb/tb_level_manager.sv
// tb_level_manager: scoreboard bench for level_manager with directed game scenarios
module tb_level_manager;
    localparam int NL = 11;
    localparam int SW = 4;

    logic clk = 0, reset = 1, tick = 0, death = 0, win = 0, start = 0;
    logic [NL*SW-1:0] base, speed;
    logic [3:0] level;
    logic [1:0] lives, gs;
    logic rr, flash;

    typedef struct {
        string      name;
        logic [1:0] st;
        logic [3:0] lvl;
        logic [1:0] lv;
        logic       rr;
        logic       fl;
        logic [3:0] sp0;
    } exp_t;

    exp_t q[$];
    int checks = 0, errors = 0;

    level_manager #(.FLASH_TICKS(2)) dut (
        .clk(clk), .reset(reset), .tick(tick), .death_collision(death),
        .win_collision(win), .start(start), .lane_base_speed(base),
        .lane_speed(speed), .current_level(level), .lives(lives),
        .game_state(gs), .round_reset(rr), .flash(flash)
    );

    always #5 clk = ~clk;

    // monitor: compare each queued expectation against the DUT away from the clock edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (gs !== e.st || level !== e.lvl || lives !== e.lv || rr !== e.rr ||
                flash !== e.fl || speed[SW-1:0] !== e.sp0) begin
                errors++;
                $display("FAIL %s: got st=%0d lvl=%0d lives=%0d rr=%0b flash=%0b sp0=%0d, want st=%0d lvl=%0d lives=%0d rr=%0b flash=%0b sp0=%0d",
                         e.name, gs, level, lives, rr, flash, speed[SW-1:0],
                         e.st, e.lvl, e.lv, e.rr, e.fl, e.sp0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic cyc(input logic d, input logic w, input logic s, input logic t);
        death = d; win = w; start = s; tick = t;
        @(posedge clk);
        #1;
        death = 0; win = 0; start = 0; tick = 0;
    endtask

    task automatic expect_st(input string n, input logic [1:0] st, input int lvl, input int lv,
                             input logic fl, input int sp0);
        exp_t e;
        e.name = n; e.st = st; e.lvl = 4'(lvl); e.lv = 2'(lv);
        e.rr = (st != 2'd0); e.fl = fl; e.sp0 = 4'(sp0);
        q.push_back(e);
    endtask

    task automatic set_base0(input int b);
        base[SW-1:0] = 4'(b);
    endtask

    initial begin
        for (int i = 0; i < NL; i++) base[i*SW +: SW] = 4'd2;
        set_base0(12);
        @(posedge clk); #1;
        reset = 0;
        expect_st("reset", 0, 1, 3, 0, 11);

        cyc(1, 0, 0, 0); expect_st("death_enter", 1, 1, 3, 0, 11);
        cyc(0, 0, 0, 1); expect_st("death_tick1", 1, 1, 3, 1, 11);
        cyc(0, 0, 0, 0); expect_st("death_notick", 1, 1, 3, 1, 11);
        cyc(0, 0, 0, 1); expect_st("death_done", 0, 1, 2, 0, 11);

        cyc(0, 1, 0, 1); expect_st("win_enter_tick", 2, 1, 2, 0, 11);
        cyc(0, 0, 0, 1); expect_st("win_tick1", 2, 1, 2, 1, 11);
        cyc(0, 0, 0, 1); expect_st("win_done", 0, 2, 2, 0, 11);
        cyc(0, 0, 0, 0); expect_st("speed_lag", 0, 2, 2, 0, 10);

        for (int l = 3; l <= 8; l++) begin
            cyc(0, 1, 0, 0); expect_st("win_loop_enter", 2, l - 1, 2, 0, 13 - l);
            cyc(0, 0, 0, 1); expect_st("win_loop_tick", 2, l - 1, 2, 1, 13 - l);
            cyc(0, 0, 0, 1); expect_st("win_loop_done", 0, l, 2, 0, 13 - l);
            cyc(0, 0, 0, 0); expect_st("win_loop_speed", 0, l, 2, 0, 12 - l);
        end
        cyc(0, 1, 0, 0); expect_st("wrap_enter", 2, 8, 2, 0, 4);
        cyc(0, 0, 0, 1); expect_st("wrap_tick", 2, 8, 2, 1, 4);
        cyc(0, 0, 0, 1); expect_st("wrap_level", 0, 1, 2, 0, 4);
        cyc(0, 0, 0, 0); expect_st("wrap_speed", 0, 1, 2, 0, 11);

        cyc(1, 1, 0, 0); expect_st("both_collide", 1, 1, 2, 0, 11);
        cyc(0, 1, 0, 1); expect_st("win_ignored", 1, 1, 2, 1, 11);
        cyc(0, 0, 0, 1); expect_st("death2_done", 0, 1, 1, 0, 11);
        cyc(0, 0, 1, 0); expect_st("start_ignored", 0, 1, 1, 0, 11);
        cyc(1, 0, 0, 0); expect_st("death3_enter", 1, 1, 1, 0, 11);
        cyc(0, 0, 0, 1); expect_st("death3_tick", 1, 1, 1, 1, 11);
        cyc(0, 0, 1, 1); expect_st("game_over", 3, 1, 0, 0, 11);
        cyc(1, 1, 0, 1); expect_st("over_hold", 3, 1, 0, 0, 11);
        cyc(0, 0, 1, 0); expect_st("restart", 0, 1, 3, 0, 11);

        for (int l = 2; l <= 5; l++) begin
            cyc(0, 1, 0, 0);
            cyc(0, 0, 0, 1);
            cyc(0, 0, 0, 1);
        end
        cyc(0, 0, 0, 0); expect_st("level5", 0, 5, 3, 0, 7);
        set_base0(2);
        cyc(0, 0, 0, 0); expect_st("saturate", 0, 5, 3, 0, 1);
        cyc(0, 1, 0, 0); expect_st("win_mid", 2, 5, 3, 0, 1);
        cyc(0, 0, 0, 1); expect_st("win_mid_tick", 2, 5, 3, 1, 1);
        reset = 1;
        cyc(0, 0, 0, 1);
        reset = 0;
        expect_st("reset_mid_win", 0, 1, 3, 0, 1);
        set_base0(12);
        cyc(0, 0, 0, 0); expect_st("after_reset_speed", 0, 1, 3, 0, 11);

        @(negedge clk); #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations unchecked, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/level_manager.md
LEVEL_MANAGER -- requirements
Module: level_manager

Interface
REQ-001 SHALL have parameter NUM_LANES, default 11: number of car lanes served.
REQ-002 SHALL have parameter SPEED_W, default 4: width of each lane speed field.
REQ-003 SHALL have parameter MAX_LEVEL, default 8: highest level, range 1..15.
REQ-004 SHALL have parameter START_LIVES, default 3: lives at game start, range 1..3.
REQ-005 SHALL have parameter FLASH_TICKS, default 50: length of the death/win pause in tick pulses, minimum 1.
REQ-006 SHALL have port clk, input, 1: the single system clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port tick, input, 1: one-clk-wide game-rate enable pulse from the clock divider.
REQ-009 SHALL have port death_collision, input, 1: frog overlaps a car.
REQ-010 SHALL have port win_collision, input, 1: frog has reached the goal row.
REQ-011 SHALL have port start, input, 1: restart request, honoured only in OVER.
REQ-012 SHALL have port lane_base_speed, input, NUM_LANES*SPEED_W: per-lane base speed; lane i in bits [i*SPEED_W +: SPEED_W].
REQ-013 SHALL have port lane_speed, output, NUM_LANES*SPEED_W: registered per-lane effective speed, same packing.
REQ-014 SHALL have port current_level, output, 4: current level, 1..MAX_LEVEL.
REQ-015 SHALL have port lives, output, 2: remaining lives.
REQ-016 SHALL have port game_state, output, 2: PLAY=0, DEATH=1, WIN=2, OVER=3.
REQ-017 SHALL have port round_reset, output, 1: holds the frog and cars at their start positions.
REQ-018 SHALL have port flash, output, 1: blink strobe for the display during the pause.

Function
REQ-019 SHALL implement the FSM PLAY, DEATH, WIN, OVER, with game_state equal to the registered state.
REQ-020 In PLAY, death_collision=1 SHALL move to DEATH and win_collision=1 SHALL move to WIN, both on the next edge; death wins when both are high in the same cycle.
REQ-021 Entering DEATH or WIN SHALL load pause counter = FLASH_TICKS; the counter SHALL decrement only on cycles with tick=1.
REQ-022 DEATH, on the tick that brings the counter to 0: lives=1 -> OVER with lives=0; otherwise lives-1 and return to PLAY.
REQ-023 WIN, on the tick that brings the counter to 0: level = (level==MAX_LEVEL) ? 1 : level+1, lives unchanged, return to PLAY.
REQ-024 OVER SHALL hold all state; start=1 SHALL load level=1, lives=START_LIVES and go to PLAY on the next edge.
REQ-025 Collision inputs SHALL be ignored outside PLAY, and start SHALL be ignored outside OVER.
REQ-026 round_reset SHALL be 1 in DEATH, WIN and OVER, and 0 in PLAY; it is a combinational decode of the state register.
REQ-027 flash SHALL toggle on every tick while in DEATH or WIN; it SHALL be forced to 0 on entry to PLAY or OVER.
REQ-028 lane_speed[i] SHALL be base_i - level when base_i > level, else 1 (saturating, never 0), with latency 1 clk from an input or level change.
REQ-029 All arithmetic SHALL be unsigned; no wrap-around is permitted on lives, level or speed.
REQ-030 A tick arriving in the same cycle as entry to DEATH or WIN SHALL NOT decrement the freshly loaded counter.

Reset
REQ-031 reset=1 SHALL, at the next edge and regardless of state, set: state=PLAY, current_level=1, lives=START_LIVES, pause counter=0, flash=0, and lane_speed = saturated base speeds for level 1.
REQ-032 reset SHALL take priority over every other input, including a reset asserted in mid-pause.

Verification
REQ-033 Default parameters, FLASH_TICKS=2, base=12 on lane 0: after reset, pulse death once and apply 2 ticks -> DEATH for exactly 2 ticks, then PLAY, lives=2, lane_speed[0]=11.
REQ-034 win 8 times -> level steps 1..8, and the 8th win wraps it to 1; lane_speed[0] changes from 4 (level 8) to 11 one clk after the wrap.
REQ-035 death and win high in the same cycle -> DEATH, level unchanged.
REQ-036 3 deaths -> OVER, lives=0, round_reset=1; start=1 -> PLAY, level=1, lives=3.
REQ-037 base=2 at level 5 -> lane_speed=1; reset asserted mid-WIN -> PLAY, level=1, flash=0.
